xor_mux_accum: RTL

Parametrised, registered XOR datapath built from 2:1 multiplexers (per bit: `out = a ? ~b : b`). It runs in two modes:
- **Mode 0, bitwise:** per-beat `a ^ b`.
- **Mode 1, frame accumulate:** running XOR checksum over a fixed-length frame of beats.

It sits between a valid/ready producer and consumer in the datapath and replaces ad-hoc single-bit XOR cells where a streamed, width-generic result is needed.

---
 rtl/xor_mux_pkg.sv | 14 +
 rtl/xor_mux_accum_if.sv | 27 ++
 rtl/xor_mux_accum_mux2.sv | 12 +
 rtl/xor_mux_accum.sv | 110 +++++++++++
 4 files changed

// File: rtl/xor_mux_pkg.sv
// Shared types and constants for the xor_mux_accum datapath.
// FSM state encoding and mode selectors.
package xor_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic MODE_BITWISE = 1'b0;
    localparam logic MODE_ACCUM   = 1'b1;

endpackage

// File: rtl/xor_mux_accum_if.sv
// Stream bundle for xor_mux_accum: input beat, output beat, status.
// master drives beats and consumes results; slave is the datapath.
interface xor_mux_accum_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 2
);
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [CNT_W-1:0] beat_cnt;

    modport master (
        output mode, in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_data, out_last, beat_cnt
    );

    modport slave (
        input  mode, in_valid, a, b, out_ready,
        output in_ready, out_valid, out_data, out_last, beat_cnt
    );
endinterface

// File: rtl/xor_mux_accum_mux2.sv
// Width-generic 2:1 multiplexer primitive.
// Building block for the XOR datapath (sel ? d1 : d0).
module mux2_w #(
    parameter int W = 1
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] out
);
    assign out = sel ? d1 : d0;
endmodule

// File: rtl/xor_mux_accum.sv
// Streamed XOR built from per-bit muxes: bitwise or frame checksum.
// Registered output, in_ready = !out_valid | out_ready.
module xor_mux_accum
    import xor_mux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input logic             clk,
    input logic             rst,
    xor_mux_accum_if.slave  bus
);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN - 1);

    state_t           state, state_n;
    logic             act_mode, act_mode_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ov, ov_n;
    logic             ol, ol_n;
    logic [WIDTH-1:0] od, od_n;

    logic [WIDTH-1:0] x, acc_x;
    logic             in_rdy, accept, start, m;

    // x = a ^ b and acc_x = acc ^ x, both as mux banks
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2_w #(.W(1)) u_x (
            .sel(bus.a[i]), .d0(bus.b[i]),
            .d1(~bus.b[i]), .out(x[i])
        );
        mux2_w #(.W(1)) u_acc (
            .sel(x[i]), .d0(acc[i]),
            .d1(~acc[i]), .out(acc_x[i])
        );
    end

    assign in_rdy = !ov | bus.out_ready;
    assign accept = bus.in_valid & in_rdy;
    assign start  = (state != ST_ACCUM);
    assign m      = start ? bus.mode : act_mode;

    always_comb begin
        state_n    = state;
        act_mode_n = act_mode;
        acc_n      = acc;
        cnt_n      = cnt;
        ov_n       = ov;
        ol_n       = ol;
        od_n       = od;
        if (ov & bus.out_ready) begin
            ov_n = 1'b0;
            ol_n = 1'b0;
        end
        if (accept) begin
            if (start) act_mode_n = bus.mode;
            if (m == MODE_BITWISE) begin
                od_n    = x;
                ov_n    = 1'b1;
                ol_n    = 1'b0;
                state_n = ST_HOLD;
            end else if (cnt == CNT_MAX) begin
                od_n    = acc_x;
                ov_n    = 1'b1;
                ol_n    = 1'b1;
                acc_n   = '0;
                cnt_n   = '0;
                state_n = ST_HOLD;
            end else begin
                acc_n   = acc_x;
                cnt_n   = cnt + 1'b1;
                state_n = ST_ACCUM;
            end
        end else begin
            unique case (state)
                ST_HOLD:  if (bus.out_ready) state_n = ST_IDLE;
                ST_IDLE,
                ST_ACCUM: state_n = state;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            act_mode <= MODE_BITWISE;
            acc      <= '0;
            cnt      <= '0;
            ov       <= 1'b0;
            ol       <= 1'b0;
            od       <= '0;
        end else begin
            state    <= state_n;
            act_mode <= act_mode_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            ov       <= ov_n;
            ol       <= ol_n;
            od       <= od_n;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = ov;
    assign bus.out_last  = ol;
    assign bus.out_data  = od;
    assign bus.beat_cnt  = cnt;
endmodule
